// File: rtl/lv_rdchk256.sv
// lv_rdchk256: self-synchronising checker for a 256-bit pseudo-random word stream.
// Optional stuck-zero detection is enabled by defining LV_RDCHK_ZERO_EN.
module lv_rdchk256 #(
    parameter int LOCK_CNT = 4,
    parameter int LOSS_CNT = 3,
    parameter int CNTW     = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            vld,
    input  logic [255:0]    din,
    output logic            locked,
    output logic            err,
    output logic [CNTW-1:0] errcnt,
    output logic [1:0]      state
);

    localparam int SW = (LOCK_CNT < 1) ? 1 : $clog2(LOCK_CNT + 1);
    localparam int MW = (LOSS_CNT < 1) ? 1 : $clog2(LOSS_CNT + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SYNC = 2'd1,
        LOCK = 2'd2
    } state_t;

    state_t          st;
    logic [255:0]    exp;
    logic [SW-1:0]   sync_cnt;
    logic [MW-1:0]   miss_cnt;
    logic [SW-1:0]   sync_next;
    logic [MW-1:0]   miss_next;
    logic [CNTW-1:0] errcnt_next;
    logic            match;

    // One step of the generator: shift right, bit 0 wraps to the top and feeds the taps.
    function automatic logic [255:0] step(input logic [255:0] x);
        step = {x[0], x[255], x[254] ^ x[0], x[253], x[252], x[251] ^ x[0],
                x[250:247], x[246] ^ x[0], x[245:1]};
    endfunction

    assign match       = (din == exp);
    assign sync_next   = sync_cnt + SW'(1);
    assign miss_next   = miss_cnt + MW'(1);
    assign errcnt_next = (errcnt == {CNTW{1'b1}}) ? errcnt : errcnt + CNTW'(1);
    assign state       = st;

    // In LOCK a mismatch flywheels exp forward so a single bad word does not break tracking.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st       <= IDLE;
            exp      <= '0;
            sync_cnt <= '0;
            miss_cnt <= '0;
            locked   <= 1'b0;
            err      <= 1'b0;
            errcnt   <= '0;
        end else begin
            err <= 1'b0;
            if (vld) begin
`ifdef LV_RDCHK_ZERO_EN
                if (din == '0) begin
                    if (st == LOCK) begin
                        err    <= 1'b1;
                        errcnt <= errcnt_next;
                    end
                    st       <= IDLE;
                    exp      <= '0;
                    sync_cnt <= '0;
                    miss_cnt <= '0;
                    locked   <= 1'b0;
                end else
`endif
                begin
                    case (st)
                        IDLE: begin
                            exp      <= step(din);
                            sync_cnt <= '0;
                            st       <= SYNC;
                            locked   <= 1'b0;
                        end
                        SYNC: begin
                            exp <= step(din);
                            if (match) begin
                                sync_cnt <= sync_next;
                                if (sync_next == SW'(LOCK_CNT)) begin
                                    st       <= LOCK;
                                    miss_cnt <= '0;
                                    locked   <= 1'b1;
                                end
                            end else begin
                                sync_cnt <= '0;
                            end
                        end
                        LOCK: begin
                            if (match) begin
                                exp      <= step(din);
                                miss_cnt <= '0;
                            end else begin
                                exp      <= step(exp);
                                err      <= 1'b1;
                                errcnt   <= errcnt_next;
                                miss_cnt <= miss_next;
                                if (miss_next == MW'(LOSS_CNT)) begin
                                    st     <= IDLE;
                                    locked <= 1'b0;
                                end
                            end
                        end
                        default: begin
                            st     <= IDLE;
                            locked <= 1'b0;
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_lv_rdchk256.sv
// tb_lv_rdchk256: directed vectors with a scoreboard queue of per-cycle expected outputs.
// Honours LV_RDCHK_ZERO_EN to pick the expected all-zero-word behaviour.
module tb_lv_rdchk256;

    localparam int CNTW = 3;
    localparam logic [1:0] IDLE = 2'd0, SYNC = 2'd1, LOCK = 2'd2;

    logic            clk;
    logic            rst;
    logic            vld;
    logic [255:0]    din;
    logic            locked;
    logic            err;
    logic [CNTW-1:0] errcnt;
    logic [1:0]      state;

    typedef struct packed {
        logic            locked;
        logic            err;
        logic [CNTW-1:0] errcnt;
        logic [1:0]      state;
    } exp_t;

    exp_t sbq[$];
    int   vectors     = 0;
    int   miscompares = 0;

    lv_rdchk256 #(.LOCK_CNT(4), .LOSS_CNT(3), .CNTW(CNTW)) dut (
        .clk    (clk),
        .rst    (rst),
        .vld    (vld),
        .din    (din),
        .locked (locked),
        .err    (err),
        .errcnt (errcnt),
        .state  (state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference generator written as a shift plus tap corrections.
    function automatic logic [255:0] stepTb(input logic [255:0] x);
        logic [255:0] n;
        n      = x >> 1;
        n[255] = x[0];
        n[253] = n[253] ^ x[0];
        n[250] = n[250] ^ x[0];
        n[245] = n[245] ^ x[0];
        return n;
    endfunction

    task automatic checkOutput(input string name, input exp_t want);
        exp_t got;
        got = '{locked, err, errcnt, state};
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("[TB] FAIL %s #%0d: got locked=%0b err=%0b errcnt=%0d state=%0d, want locked=%0b err=%0b errcnt=%0d state=%0d",
                     name, vectors, got.locked, got.err, got.errcnt, got.state,
                     want.locked, want.err, want.errcnt, want.state);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [255:0] d, input logic l,
                                 input logic e, input int c, input logic [1:0] s);
        exp_t want;
        @(negedge clk);
        vld  = v;
        din  = d;
        want = '{l, e, CNTW'(c), s};
        sbq.push_back(want);
    endtask

    task automatic doReset();
        exp_t zero;
        zero = '{1'b0, 1'b0, '0, IDLE};
        @(negedge clk);
        vld = 1'b0;
        rst = 1'b1;
        #1;
        checkOutput("async_reset", zero);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Monitor: each edge that has a pending expectation is checked just after the edge.
    initial begin
        forever begin
            @(posedge clk);
            if (sbq.size() > 0) begin
                exp_t want;
                want = sbq.pop_front();
                #1;
                checkOutput("cycle", want);
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, want finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [255:0] cur;
        logic [255:0] w;
        exp_t         rst_want;
        int           cnt;

        rst = 1'b1;
        vld = 1'b0;
        din = '0;
        repeat (2) @(negedge clk);
        rst_want = '{1'b0, 1'b0, '0, IDLE};
        checkOutput("reset_state", rst_want);
        rst = 1'b0;

        // Lock acquisition from S = 1, then a vld=0 cycle with junk on din.
        cur = 256'h1;
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1'b1, cur, k == 4, 1'b0, 0, (k == 4) ? LOCK : SYNC);
            cur = stepTb(cur);
        end
        applyStimulus(1'b0, {8{32'hCAFEF00D}}, 1'b1, 1'b0, 0, LOCK);

        // Single corrupted word: err once, flywheel keeps lock.
        applyStimulus(1'b1, cur ^ 256'h1, 1'b1, 1'b1, 1, LOCK);
        cur = stepTb(cur);
        applyStimulus(1'b1, cur, 1'b1, 1'b0, 1, LOCK);
        cur = stepTb(cur);
        applyStimulus(1'b1, cur, 1'b1, 1'b0, 1, LOCK);
        cur = stepTb(cur);

        // Three junk words drop lock; then relock on a fresh sequence.
        applyStimulus(1'b1, {8{32'hDEADBEEF}}, 1'b1, 1'b1, 2, LOCK);
        applyStimulus(1'b1, {8{32'h13579BDF}}, 1'b1, 1'b1, 3, LOCK);
        applyStimulus(1'b1, {8{32'h02468ACE}}, 1'b0, 1'b1, 4, IDLE);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 4, IDLE);
        cur = {16{16'hA5C3}};
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1'b1, cur, k == 4, 1'b0, 4, (k == 4) ? LOCK : SYNC);
            cur = stepTb(cur);
        end

        // All-zero word while locked.
`ifdef LV_RDCHK_ZERO_EN
        applyStimulus(1'b1, '0, 1'b0, 1'b1, 5, IDLE);
        cur = stepTb(cur);
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1'b1, cur, k == 4, 1'b0, 5, (k == 4) ? LOCK : SYNC);
            cur = stepTb(cur);
        end
`else
        applyStimulus(1'b1, '0, 1'b1, 1'b1, 5, LOCK);
        cur = stepTb(cur);
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1'b1, cur, 1'b1, 1'b0, 5, LOCK);
            cur = stepTb(cur);
        end
`endif

        // Alternating bad/good words: miss counter clears, errcnt saturates at 7.
        for (int i = 0; i < 3; i++) begin
            cnt = (6 + i > 7) ? 7 : 6 + i;
            applyStimulus(1'b1, cur ^ 256'h1, 1'b1, 1'b1, cnt, LOCK);
            cur = stepTb(cur);
            applyStimulus(1'b1, cur, 1'b1, 1'b0, cnt, LOCK);
            cur = stepTb(cur);
        end

        // Reset mid-lock, then the next word is a new seed.
        doReset();
        applyStimulus(1'b1, cur, 1'b0, 1'b0, 0, SYNC);

        // Sync-phase mismatch, preceded by an all-zero word from IDLE.
        doReset();
`ifdef LV_RDCHK_ZERO_EN
        applyStimulus(1'b1, '0, 1'b0, 1'b0, 0, IDLE);
`else
        applyStimulus(1'b1, '0, 1'b0, 1'b0, 0, SYNC);
`endif
        cur = 256'h1;
        applyStimulus(1'b1, cur, 1'b0, 1'b0, 0, SYNC);
        applyStimulus(1'b1, stepTb(cur), 1'b0, 1'b0, 0, SYNC);
        w = {8{32'h12345678}};
        applyStimulus(1'b1, w, 1'b0, 1'b0, 0, SYNC);
        cur = stepTb(w);
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b1, cur, k == 3, 1'b0, 0, (k == 3) ? LOCK : SYNC);
            cur = stepTb(cur);
        end

        // Lock acquisition with vld=0 gaps of 1-3 cycles.
        doReset();
        cur = 256'h1;
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1'b1, cur, k == 4, 1'b0, 0, (k == 4) ? LOCK : SYNC);
            cur = stepTb(cur);
            if (k < 4) begin
                for (int g = 0; g < (k % 3) + 1; g++) begin
                    applyStimulus(1'b0, ~cur, 1'b0, 1'b0, 0, SYNC);
                end
            end
        end
        applyStimulus(1'b0, '0, 1'b1, 1'b0, 0, LOCK);

        repeat (3) @(negedge clk);
        vld = 1'b0;
        if (sbq.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL drain: %0d expectations left, want 0", sbq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
